// File: rtl/rmt_pkg.sv
// Shared constants for the match-action stages: PHV/action widths, table
// geometry, sub-action opcodes and field positions.
package rmt_pkg;

  localparam int PHV_LEN   = 1124;
  localparam int ACT_LEN   = 25;
  localparam int ACT_SUBS  = 25;
  localparam int ACT_WORD  = ACT_LEN * ACT_SUBS;
  localparam int ACT_DEPTH = 16;
  localparam int ACT_AW    = $clog2(ACT_DEPTH);

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_ADDI = 4'b1001;
  localparam logic [3:0] OP_SUBI = 4'b1010;
  localparam logic [3:0] OP_SET  = 4'b1000;
  localparam logic [3:0] OP_LOAD = 4'b1011;

  localparam int OPC_HI = 24;
  localparam int OPC_LO = 21;
  localparam int OP1_HI = 18;
  localparam int OP1_LO = 16;
  localparam int OP2_HI = 13;
  localparam int OP2_LO = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  function automatic logic [3:0] sub_opcode(input logic [ACT_LEN-1:0] sub);
    return sub[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/phv_fifo.sv
// Synchronous FIFO with head-of-queue read; a push to a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module phv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign overflow  = push && !push_ok;
  assign underflow = pop && empty;
  assign pop_data  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/action_fetch.sv
// Buffers PHVs until their lookup result arrives, then emits the head PHV
// together with its action word so the crossbar sees them aligned.
module action_fetch #(
  parameter int STAGE      = 0,
  parameter int PHV_LEN    = rmt_pkg::PHV_LEN,
  parameter int ACT_LEN    = rmt_pkg::ACT_LEN,
  parameter int ACT_DEPTH  = rmt_pkg::ACT_DEPTH,
  parameter int ACT_AW     = $clog2(ACT_DEPTH),
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PHV_LEN-1:0]           phv_in,
  input  logic                         phv_in_valid,
  input  logic                         lkp_valid,
  input  logic                         lkp_hit,
  input  logic [ACT_AW-1:0]            lkp_addr,
  input  logic                         cfg_wr_en,
  input  logic [ACT_AW-1:0]            cfg_wr_addr,
  input  logic [ACT_LEN*25-1:0]        cfg_wr_data,
  input  logic                         cfg_clr,
  output logic [PHV_LEN-1:0]           phv_out,
  output logic                         phv_out_valid,
  output logic [ACT_LEN*25-1:0]        action_out,
  output logic                         action_out_valid,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         err_overflow,
  output logic                         err_underflow
);
  import rmt_pkg::*;

  localparam int ACT_W = ACT_LEN * ACT_SUBS;

  if (STAGE < 0) begin : g_stage_chk
    $error("action_fetch: STAGE must be non-negative");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("action_fetch: FIFO_DEPTH must be a power of two");
  end

  logic [ACT_W-1:0]     act_table [ACT_DEPTH];
  logic [ACT_DEPTH-1:0] entry_valid;

  logic [PHV_LEN-1:0]   head_phv;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 ovf_pulse;
  logic                 unf_pulse;
  logic                 pop_ok;
  logic [ACT_W-1:0]     sel_action;

  phv_fifo #(
    .WIDTH (PHV_LEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (phv_in_valid),
    .push_data (phv_in),
    .pop       (lkp_valid),
    .pop_data  (head_phv),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (ovf_pulse),
    .underflow (unf_pulse)
  );

  assign pop_ok = lkp_valid && !fifo_empty;

  // Miss or invalid entry yields an all-NOP word; the read sees pre-write state.
  assign sel_action = (lkp_hit && entry_valid[lkp_addr]) ? act_table[lkp_addr] : '0;

  always_ff @(posedge clk) begin
    if (cfg_wr_en) act_table[cfg_wr_addr] <= cfg_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_valid <= '0;
    end else if (cfg_clr) begin
      entry_valid <= '0;
    end else if (cfg_wr_en) begin
      entry_valid[cfg_wr_addr] <= 1'b1;
    end
  end

  // Output register: PHV and action load together, valid pulses per pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phv_out       <= '0;
      action_out    <= '0;
      phv_out_valid <= 1'b0;
    end else begin
      phv_out_valid <= pop_ok;
      if (pop_ok) begin
        phv_out    <= head_phv;
        action_out <= sel_action;
      end
    end
  end

  assign action_out_valid = phv_out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (ovf_pulse) err_overflow  <= 1'b1;
      if (unf_pulse) err_underflow <= 1'b1;
    end
  end

  full_count_a: assert property (@(posedge clk) disable iff (rst)
    fifo_full |-> (fifo_count == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH)));

endmodule

// File: tb/tb_action_fetch.sv
// Randomized scoreboard bench for action_fetch with a queue-based reference model.
module tb_action_fetch;

  localparam int PW = 1124;
  localparam int AW = 625;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] phv_in;
  logic          phv_in_valid;
  logic          lkp_valid;
  logic          lkp_hit;
  logic [3:0]    lkp_addr;
  logic          cfg_wr_en;
  logic [3:0]    cfg_wr_addr;
  logic [AW-1:0] cfg_wr_data;
  logic          cfg_clr;
  logic [PW-1:0] phv_out;
  logic          phv_out_valid;
  logic [AW-1:0] action_out;
  logic          action_out_valid;
  logic [2:0]    fifo_count;
  logic          err_overflow;
  logic          err_underflow;

  action_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .phv_in           (phv_in),
    .phv_in_valid     (phv_in_valid),
    .lkp_valid        (lkp_valid),
    .lkp_hit          (lkp_hit),
    .lkp_addr         (lkp_addr),
    .cfg_wr_en        (cfg_wr_en),
    .cfg_wr_addr      (cfg_wr_addr),
    .cfg_wr_data      (cfg_wr_data),
    .cfg_clr          (cfg_clr),
    .phv_out          (phv_out),
    .phv_out_valid    (phv_out_valid),
    .action_out       (action_out),
    .action_out_valid (action_out_valid),
    .fifo_count       (fifo_count),
    .err_overflow     (err_overflow),
    .err_underflow    (err_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected outputs, in order.
  logic [PW-1:0] exp_phv_q [$];
  logic [AW-1:0] exp_act_q [$];

  // Reference model: a bounded queue of PHVs, the table and its valid bits.
  logic [PW-1:0] m_fifo [$];
  logic [AW-1:0] m_tab [16];
  bit            m_val [16];
  bit            m_ovf;
  bit            m_unf;

  function automatic logic [PW-1:0] rand_phv();
    logic [36*32-1:0] r;
    for (int i = 0; i < 36; i++) r[i*32 +: 32] = $urandom;
    return r[PW-1:0];
  endfunction

  function automatic logic [AW-1:0] rand_act();
    logic [20*32-1:0] r;
    for (int i = 0; i < 20; i++) r[i*32 +: 32] = $urandom;
    return r[AW-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock of stimulus; the model is advanced from the pre-edge state.
  task automatic step(input bit push, input logic [PW-1:0] d, input bit lkp, input bit hit,
                      input logic [3:0] la, input bit wr, input logic [3:0] wa,
                      input logic [AW-1:0] wd, input bit clr);
    phv_in_valid = push; phv_in = d;
    lkp_valid = lkp; lkp_hit = hit; lkp_addr = la;
    cfg_wr_en = wr; cfg_wr_addr = wa; cfg_wr_data = wd; cfg_clr = clr;
    if (lkp) begin
      if (m_fifo.size() > 0) begin
        exp_phv_q.push_back(m_fifo.pop_front());
        exp_act_q.push_back((hit && m_val[la]) ? m_tab[la] : '0);
      end else begin
        m_unf = 1;
      end
    end
    if (push) begin
      if (m_fifo.size() < 4) m_fifo.push_back(d);
      else m_ovf = 1;
    end
    if (wr) m_tab[wa] = wd;
    if (clr) begin
      for (int i = 0; i < 16; i++) m_val[i] = 0;
    end else if (wr) begin
      m_val[wa] = 1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("fifo_count", 64'(fifo_count), 64'(m_fifo.size()));
    chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
    chk("err_underflow", 64'(err_underflow), 64'(m_unf));
  endtask

  task automatic idle();
    step(0, '0, 0, 0, '0, 0, '0, '0, 0);
  endtask

  task automatic push_one(input logic [PW-1:0] d);
    step(1, d, 0, 0, '0, 0, '0, '0, 0);
  endtask

  task automatic lookup(input bit hit, input logic [3:0] la);
    step(0, '0, 1, hit, la, 0, '0, '0, 0);
  endtask

  task automatic cfg_write(input logic [3:0] wa, input logic [AW-1:0] wd);
    step(0, '0, 0, 0, '0, 1, wa, wd, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  always @(negedge clk) begin
    if (!rst) begin
      if (action_out_valid !== phv_out_valid) begin
        checks++; errors++;
        $display("FAIL valid_align: action_out_valid %b phv_out_valid %b",
                 action_out_valid, phv_out_valid);
      end
      if (phv_out_valid === 1'b1) begin
        checks++;
        if (exp_phv_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: phv_out low bits %0h with nothing expected",
                   phv_out[63:0]);
        end else begin
          logic [PW-1:0] ep;
          logic [AW-1:0] ea;
          ep = exp_phv_q.pop_front();
          ea = exp_act_q.pop_front();
          if (phv_out !== ep) begin
            errors++;
            $display("FAIL phv_out: got low bits %0h expected %0h", phv_out[63:0], ep[63:0]);
          end
          checks++;
          if (action_out !== ea) begin
            errors++;
            $display("FAIL action_out: got %0h expected %0h", action_out, ea);
          end
        end
      end
    end
  end

  initial begin
    logic [PW-1:0] phv_a;
    logic [AW-1:0] w3;
    logic [AW-1:0] v1;
    logic [AW-1:0] v2;

    rst = 1'b1;
    phv_in_valid = 0; phv_in = '0; lkp_valid = 0; lkp_hit = 0; lkp_addr = '0;
    cfg_wr_en = 0; cfg_wr_addr = '0; cfg_wr_data = '0; cfg_clr = 0;
    for (int i = 0; i < 16; i++) begin m_tab[i] = '0; m_val[i] = 0; end
    m_ovf = 0; m_unf = 0;
    @(negedge clk); @(negedge clk);
    chk("reset_phv_out_valid", 64'(phv_out_valid), 64'd0);
    chk("reset_action_out_valid", 64'(action_out_valid), 64'd0);
    chk("reset_phv_out_zero", 64'(phv_out != '0), 64'd0);
    chk("reset_fifo_count", 64'(fifo_count), 64'd0);
    chk("reset_err_flags", {62'd0, err_overflow, err_underflow}, 64'd0);
    rst = 1'b0;

    // Basic hit
    w3 = {25{25'h0210800}};
    phv_a = '0; phv_a[7:0] = 8'hA5; phv_a[PW-1] = 1'b1;
    cfg_write(4'd3, w3);
    push_one(phv_a);
    lookup(1, 4'd3);
    idle();

    // Miss, then hit to an entry never written
    push_one(rand_phv());
    push_one(rand_phv());
    lookup(0, 4'd3);
    lookup(1, 4'd7);
    idle();

    // Underflow, including push+pop on empty
    lookup(1, 4'd3);
    step(1, rand_phv(), 1, 1, 4'd3, 0, '0, '0, 0);
    lookup(1, 4'd3);

    // Full FIFO with push and pop together: no overflow
    for (int i = 0; i < 4; i++) push_one(rand_phv());
    step(1, rand_phv(), 1, 1, 4'd3, 0, '0, '0, 0);
    for (int i = 0; i < 4; i++) lookup(1, 4'd3);

    // Overflow: fifth push is dropped
    for (int i = 0; i < 5; i++) push_one(rand_phv());
    for (int i = 0; i < 4; i++) lookup(1, 4'd3);
    idle();

    // Clear has priority over a same-cycle write
    cfg_write(4'd2, rand_act());
    step(0, '0, 0, 0, '0, 1, 4'd2, rand_act(), 1);
    push_one(rand_phv());
    lookup(1, 4'd2);

    // Read-before-write on the same index
    v1 = rand_act(); v2 = rand_act();
    cfg_write(4'd5, v1);
    push_one(rand_phv());
    step(0, '0, 1, 1, 4'd5, 1, 4'd5, v2, 0);
    push_one(rand_phv());
    lookup(1, 4'd5);
    idle();

    // Randomized traffic
    cfg_write(4'd3, w3);
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 99) < 55, rand_phv(),
           $urandom_range(0, 99) < 50, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 99) < 20, 4'($urandom_range(0, 15)), rand_act(),
           $urandom_range(0, 99) < 3);
    end
    for (int i = 0; i < 5; i++) lookup(1, 4'd0);
    idle();

    // Reset mid-stream with three PHVs buffered and an output valid
    cfg_write(4'd3, w3);
    for (int i = 0; i < 4; i++) push_one(rand_phv());
    lookup(1, 4'd3);
    chk("pre_reset_valid", 64'(phv_out_valid), 64'd1);
    chk("pre_reset_count", 64'(fifo_count), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_phv_out_valid", 64'(phv_out_valid), 64'd0);
    chk("async_reset_action_out_valid", 64'(action_out_valid), 64'd0);
    chk("async_reset_phv_out_zero", 64'(phv_out != '0), 64'd0);
    chk("async_reset_action_out_zero", 64'(action_out != '0), 64'd0);
    chk("async_reset_fifo_count", 64'(fifo_count), 64'd0);
    chk("scoreboard_drained_at_reset", 64'(exp_phv_q.size()), 64'd0);
    m_fifo.delete();
    exp_phv_q.delete();
    exp_act_q.delete();
    for (int i = 0; i < 16; i++) m_val[i] = 0;
    m_ovf = 0; m_unf = 0;
    @(negedge clk);
    rst = 1'b0;

    // After reset every entry is invalid even though table data survives
    push_one(rand_phv());
    lookup(1, 4'd3);
    push_one(rand_phv());
    lookup(1, 4'd5);
    idle();
    idle();
    chk("scoreboard_empty_at_end", 64'(exp_phv_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/action_fetch.md
# action_fetch

Stage-local action fetch placed directly upstream of the crossbar. It buffers incoming PHVs while the match lookup is in flight, then reads the 625-bit action word selected by the lookup result from a 16-entry action table. It emits the head PHV and its action word in the same cycle, so the crossbar receives `phv_in`/`action_in` already aligned. The control plane loads the action table through a simple write port.

## Interface
- `STAGE`, 0: stage index; informational only, no effect on logic.
- `PHV_LEN`, 1124: PHV width (8×48 + 8×32 + 8×16 + 100 + 256).
- `ACT_LEN`, 25: sub-action width; the action word is `ACT_LEN*25` = 625 bits.
- `ACT_DEPTH`, 16: number of action table entries; `ACT_AW` = log2(ACT_DEPTH) = 4.
- `FIFO_DEPTH`, 4: PHV buffer depth; power of 2.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `phv_in`  in  PHV_LEN  PHV from the parser or previous stage.
- `phv_in_valid`  in  1  one PHV per asserted cycle.
- `lkp_valid`  in  1  lookup result for the oldest outstanding PHV.
- `lkp_hit`  in  1  1 = hit, 0 = miss.
- `lkp_addr`  in  ACT_AW  action table index; used only on a hit.
- `cfg_wr_en`  in  1  action table write strobe.
- `cfg_wr_addr`  in  ACT_AW  write index.
- `cfg_wr_data`  in  ACT_LEN*25  action word to store.
- `cfg_clr`  in  1  invalidates all table entries in one cycle.
- `phv_out`  out  PHV_LEN  registered; goes to the crossbar `phv_in`.
- `phv_out_valid`  out  1  goes to the crossbar `phv_in_valid`.
- `action_out`  out  ACT_LEN*25  goes to the crossbar `action_in`.
- `action_out_valid`  out  1  goes to the crossbar `action_in_valid`; always equal to `phv_out_valid`.
- `fifo_count`  out  3  current PHV occupancy, 0..4.
- `err_overflow`  out  1  sticky overflow flag; cleared only by reset.
- `err_underflow`  out  1  sticky underflow flag; cleared only by reset.

## Operation
- **PHV buffering.** On `phv_in_valid`, push `phv_in` into the FIFO.
- **Pop.** On `lkp_valid` with a non-empty FIFO, pop the head PHV.
- **Action select:**
  - hit and `entry_valid[lkp_addr]` = 1: action = `table[lkp_addr]`.
  - miss, or hit to an invalid entry: action = all-zero (every sub-action opcode 4'b0000, a no-op at the crossbar).
- **Output register.** `phv_out` and `action_out` load together. Both valids pulse for exactly one cycle per pop.
- **Table write.** `cfg_wr_en` writes `table[cfg_wr_addr]` and sets `entry_valid` for that index.
- **Table clear.** `cfg_clr` clears every `entry_valid` bit.
- **Clear vs write, same cycle.** `cfg_clr` has priority over `cfg_wr_en`; the written entry ends up invalid.
- **Read during write.** A lookup and a write to the same index in the same cycle returns the old contents and old valid bit (read-before-write).
- **Simultaneous push and pop on a non-empty FIFO.** Both take effect; `fifo_count` is unchanged.
- **Push and pop on an empty FIFO.** The pop is an underflow. The pushed PHV is stored, no output is produced, and `err_underflow` is set.
- **Push when full with no pop.** The PHV is dropped, `err_overflow` is set, and the FIFO contents are unchanged.
- **Push when full with a pop in the same cycle.** This is legal; there is no overflow.
- **Pointer wrap.** Read and write pointers wrap modulo FIFO_DEPTH. Full/empty is derived from the 3-bit `fifo_count`.
- **Reset values.** All outputs 0. `fifo_count` = 0. Pointers = 0. `entry_valid` = all 0. Table data is not reset.
- **Reset mid-operation.** Buffered PHVs are discarded. Any output valid deasserts asynchronously.

## Timing
- Lookup to output: `lkp_valid` in cycle T gives `phv_out_valid` = `action_out_valid` = 1 in T+1.
- Push to pop: a PHV pushed in cycle T can be popped by a `lkp_valid` in cycle T+1 at the earliest.
- Throughput: one PHV per cycle sustained.
- Config writes: a write in cycle T is visible to a lookup in cycle T+1.
- Error flags: `err_*` assert in the cycle after the offending event.

## Structure
- **Shared package** `rmt_pkg`:
  - `PHV_LEN`, `ACT_LEN`, `ACT_WORD = ACT_LEN*25`, `ACT_DEPTH`.
  - Opcode constants: `OP_NOP` = 4'b0000, `OP_ADD` = 4'b0001, `OP_SUB` = 4'b0010, `OP_ADDI` = 4'b1001, `OP_SUBI` = 4'b1010, `OP_SET` = 4'b1000, `OP_LOAD` = 4'b1011.
  - Sub-action field positions: opcode [24:21], op1 [18:16], op2 [13:11], immediate [15:0].
- **Sub-module** `phv_fifo`: parameterised width/depth synchronous FIFO. Ports: push/pop, count, full, empty, overflow/underflow pulses.
- **Top level** holds the action table, the valid bits and the output register.

## Test plan
- **Basic hit.** Write `table[3]` = {25{25'h0210800}}. Push PHV A (`phv_in` = 1124'h1…A5) at T0, lookup hit addr 3 at T1 -> at T2 `phv_out` = A, `action_out` = that word, both valids = 1 for one cycle.
- **Miss and invalid entry.** Push B and C. Lookup miss, then hit to unwritten addr 7 -> two outputs, both with `action_out` = 0, in push order.
- **Overflow.** Push 5 PHVs with no lookups -> `fifo_count` = 4, `err_overflow` = 1. Then 4 lookups return PHVs 1..4 only.
- **Underflow and corner cases.** Lookup with empty FIFO -> no output, `err_underflow` = 1. Full FIFO with push+pop in the same cycle -> count stays 4, no error.
- **Clear/write and read-before-write.** `cfg_clr` + `cfg_wr_en` addr 2 in the same cycle, then hit addr 2 -> action 0. Write addr 5 in the same cycle as a hit to addr 5 -> old data returned.
- **Reset mid-stream.** Assert `rst` with 3 PHVs buffered and `phv_out_valid` high -> outputs 0 immediately, `fifo_count` = 0. Post-reset hits return zero action (all entries invalid).
